sifreleme_yurutme_asamasi: RTL and testbench
============================================

Name: sifreleme_yurutme_asamasi

Overview:
- Execute-stage wrapper around the combinational sifreleme_birimi.
- Accepts issued crypto instructions from decode/issue with a valid/ready handshake and registers the operands in one pipeline stage.
- Evaluates them through an internal sifreleme_birimi instance and buffers the results in a small output FIFO, which the writeback stage drains under its own valid/ready handshake.
- Supports pipeline flush and reports unsupported control codes.

Parameters:
- FIFO_DERINLIK, 4, result FIFO entries; power of two, minimum 2.
- VERI_GENISLIK, 32, operand/result width; sifreleme_birimi is fixed at 32.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- giris_gecerli_i  input  1  issue side presents a valid instruction.
- giris_hazir_o  output  1  stage can accept an instruction this cycle.
- kontrol_i  input  3  operation code, `SIFRELEME_* encoding from tanimlamalar.vh.
- deger1_i  input  32  operand 1 (rs1).
- deger2_i  input  32  operand 2 (rs2).
- hedef_yazmac_i  input  5  destination register index; carried alongside the result.
- temizle_i  input  1  synchronous flush of all in-flight and buffered work.
- cikis_gecerli_o  output  1  FIFO head holds a valid result.
- cikis_hazir_i  input  1  writeback accepts the head this cycle.
- sonuc_o  output  32  result at the FIFO head.
- hedef_yazmac_o  output  5  destination index at the FIFO head.
- gecersiz_islem_o  output  1  head entry came from an unsupported kontrol code.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - stage-1 valid = 0; FIFO read/write pointers and count = 0.
  - cikis_gecerli_o = 0, sonuc_o = 0, hedef_yazmac_o = 0, gecersiz_islem_o = 0, giris_hazir_o = 0.
  - giris_hazir_o rises on the first clock edge after reset deassertion.
- Handshakes:
  - Accept = giris_gecerli_i && giris_hazir_o.
  - Pop = cikis_gecerli_o && cikis_hazir_i.
  - Inputs must be held stable while giris_gecerli_i is high and not yet accepted.
- giris_hazir_o = (fifo_count + asama1_gecerli) < FIFO_DERINLIK.
  - Computed from registers only; there is no combinational path from cikis_hazir_i or giris_gecerli_i.
- Stage 1: on accept, latch kontrol, deger1, deger2, hedef and set asama1_gecerli. Otherwise clear asama1_gecerli.
- Stage 2:
  - When asama1_gecerli, push {sonuc from sifreleme_birimi, hedef, gecersiz} into the FIFO.
  - The credit rule guarantees the push never overflows; the bench asserts this.
- Latency: accept in cycle N gives cikis_gecerli_o high in cycle N+2 (FIFO empty, no flush).
- Throughput: 1 instruction/cycle sustained while cikis_hazir_i stays high.
- Simultaneous push and pop in one cycle: count is unchanged.
  - Pop with an empty FIFO is impossible by construction.
- Output side:
  - sonuc_o, hedef_yazmac_o and gecersiz_islem_o show the FIFO head while count > 0.
  - All three are 0 when the FIFO is empty.
  - The head is stable while cikis_gecerli_o && !cikis_hazir_i.
  - Order is strictly FIFO.
- Unsupported kontrol codes (the two codes not assigned to HMDST, PKG, RVRS, SLADD, CNTZ, CNTP):
  - result forced to 0, gecersiz flag = 1.
  - The entry is otherwise handled like a normal instruction.
- Pointer wrap-around: pointers are log2(FIFO_DERINLIK) bits and wrap naturally; count is a separate register.
- temizle_i high at a clock edge:
  - asama1_gecerli = 0, FIFO count and pointers = 0.
  - An accept in the same cycle is discarded.
  - A pop in the same cycle still counts as consumed by writeback.
  - Flush takes priority over push and accept.
- Reset asserted mid-operation discards everything asynchronously; there is no partial output.

Test Plan:
- HMDST, deger1=f0f0_f0f0, deger2=fff0_f0f0, cikis_hazir_i=1:
  - cikis_gecerli_o rises exactly 2 cycles after accept, sonuc_o=4.
- Back-to-back, one per cycle: PKG (ffff_000f, ffff_0f0f), RVRS (ffff_0000, 0), SLADD (16, 38), CNTZ (ffff_0000), CNTP (f000_0000):
  - in-order results 0f0f_000f, 0000_ffff, 70, 16, 4 on consecutive cycles.
  - hedef_yazmac_o tracks each entry.
- cikis_hazir_i=0, issue continuously:
  - exactly FIFO_DERINLIK instructions accepted, then giris_hazir_o=0 and the head stays constant.
  - Raise cikis_hazir_i: results drain in order and giris_hazir_o returns high.
- Unsupported kontrol code, operands 1234_5678/9abc_def0:
  - sonuc_o=0, gecersiz_islem_o=1, hedef_yazmac_o preserved.
  - The following valid op reports gecersiz_islem_o=0.
- Fill the FIFO with 3 entries and 1 in stage 1, then pulse temizle_i together with a new accept:
  - next cycle cikis_gecerli_o=0 and no result from the flushed or concurrent instructions ever appears.
- Assert rst_ni low mid-stream, asynchronously between edges:
  - all outputs go to 0 immediately.
  - After release, the first new instruction returns its correct result with 2-cycle latency.

Source files
------------

// File: rtl/sifreleme_yurutme_asamasi.sv
// Crypto execute stage: one operand register stage in front of the
// combinational sifreleme_birimi, followed by a credit-guarded result FIFO
// drained by writeback.
//
// Operation encoding (kontrol):
//   0 HMDST  popcount(deger1 ^ deger2)
//   1 PKG    {deger2[15:0], deger1[15:0]}
//   2 RVRS   byte reverse of deger1
//   3 SLADD  (deger1 << 1) + deger2
//   4 CNTZ   trailing zero count of deger1 (32 when deger1 == 0)
//   5 CNTP   popcount of deger1
//   6,7      unsupported: result 0, gecersiz = 1

// Combinational crypto unit, fixed 32-bit datapath.
module sifreleme_birimi (
    input  logic [2:0]  kontrol,
    input  logic [31:0] deger1,
    input  logic [31:0] deger2,
    output logic [31:0] sonuc,
    output logic        gecersiz
);
    localparam logic [2:0] SIFRELEME_HMDST = 3'd0;
    localparam logic [2:0] SIFRELEME_PKG   = 3'd1;
    localparam logic [2:0] SIFRELEME_RVRS  = 3'd2;
    localparam logic [2:0] SIFRELEME_SLADD = 3'd3;
    localparam logic [2:0] SIFRELEME_CNTZ  = 3'd4;
    localparam logic [2:0] SIFRELEME_CNTP  = 3'd5;

    function automatic logic [5:0] bit_say(input logic [31:0] x);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, x[i]};
        end
        return n;
    endfunction

    function automatic logic [5:0] sondaki_sifir(input logic [31:0] x);
        logic [5:0] n;
        logic       bulundu;
        n       = 6'd32;
        bulundu = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (!bulundu && x[i]) begin
                n       = 6'(i);
                bulundu = 1'b1;
            end
        end
        return n;
    endfunction

    // Operation select; unsupported codes yield zero and raise gecersiz.
    always_comb begin
        sonuc    = 32'd0;
        gecersiz = 1'b0;
        case (kontrol)
            SIFRELEME_HMDST: sonuc = {26'd0, bit_say(deger1 ^ deger2)};
            SIFRELEME_PKG:   sonuc = {deger2[15:0], deger1[15:0]};
            SIFRELEME_RVRS:  sonuc = {deger1[7:0], deger1[15:8], deger1[23:16], deger1[31:24]};
            SIFRELEME_SLADD: sonuc = {deger1[30:0], 1'b0} + deger2;
            SIFRELEME_CNTZ:  sonuc = {26'd0, sondaki_sifir(deger1)};
            SIFRELEME_CNTP:  sonuc = {26'd0, bit_say(deger1)};
            default:         gecersiz = 1'b1;
        endcase
    end
endmodule

// Execute-stage wrapper with issue/writeback handshakes and flush.
module sifreleme_yurutme_asamasi #(
    parameter int FIFO_DERINLIK = 4,
    parameter int VERI_GENISLIK = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     giris_gecerli_i,
    output logic                     giris_hazir_o,
    input  logic [2:0]               kontrol_i,
    input  logic [VERI_GENISLIK-1:0] deger1_i,
    input  logic [VERI_GENISLIK-1:0] deger2_i,
    input  logic [4:0]               hedef_yazmac_i,
    input  logic                     temizle_i,
    output logic                     cikis_gecerli_o,
    input  logic                     cikis_hazir_i,
    output logic [VERI_GENISLIK-1:0] sonuc_o,
    output logic [4:0]               hedef_yazmac_o,
    output logic                     gecersiz_islem_o
);
    localparam int PTR_W = $clog2(FIFO_DERINLIK);
    localparam int CNT_W = PTR_W + 1;

    // Stage-1 operand registers
    logic                     asama1_gecerli;
    logic [2:0]               asama1_kontrol;
    logic [VERI_GENISLIK-1:0] asama1_deger1;
    logic [VERI_GENISLIK-1:0] asama1_deger2;
    logic [4:0]               asama1_hedef;

    // Result FIFO storage and bookkeeping
    logic [VERI_GENISLIK-1:0] sonuc_mem    [FIFO_DERINLIK];
    logic [4:0]               hedef_mem    [FIFO_DERINLIK];
    logic                     gecersiz_mem [FIFO_DERINLIK];
    logic [PTR_W-1:0]         yaz_ptr;
    logic [PTR_W-1:0]         oku_ptr;
    logic [CNT_W-1:0]         sayac;

    // Ready is held low until the first edge after reset release.
    logic                     aktif;

    logic [VERI_GENISLIK-1:0] birim_sonuc;
    logic                     birim_gecersiz;
    logic [CNT_W:0]           doluluk;
    logic                     kabul;
    logic                     yaz;
    logic                     oku;

    sifreleme_birimi u_birim (
        .kontrol  (asama1_kontrol),
        .deger1   (asama1_deger1),
        .deger2   (asama1_deger2),
        .sonuc    (birim_sonuc),
        .gecersiz (birim_gecersiz)
    );

    // Credit: buffered plus in-flight entries must leave room for one more,
    // so a stage-1 push can never overflow the FIFO. Registers only.
    always_comb begin
        doluluk        = {1'b0, sayac} + {{CNT_W{1'b0}}, asama1_gecerli};
        giris_hazir_o  = aktif && (doluluk < (CNT_W+1)'(FIFO_DERINLIK));
        kabul          = giris_gecerli_i && giris_hazir_o;
        cikis_gecerli_o = (sayac != '0);
        oku            = cikis_gecerli_o && cikis_hazir_i;
        yaz            = asama1_gecerli && !temizle_i;
    end

    // Head view; everything reads zero while the FIFO is empty.
    always_comb begin
        sonuc_o          = '0;
        hedef_yazmac_o   = '0;
        gecersiz_islem_o = 1'b0;
        if (cikis_gecerli_o) begin
            sonuc_o          = sonuc_mem[oku_ptr];
            hedef_yazmac_o   = hedef_mem[oku_ptr];
            gecersiz_islem_o = gecersiz_mem[oku_ptr];
        end
    end

    // Reset-release flag for the ready output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) aktif <= 1'b0;
        else         aktif <= 1'b1;
    end

    // Stage-1 valid: set on accept, dropped otherwise or on flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        asama1_gecerli <= 1'b0;
        else if (temizle_i) asama1_gecerli <= 1'b0;
        else                asama1_gecerli <= kabul;
    end

    // Stage-1 operand capture; payload needs no reset, valid qualifies it.
    always_ff @(posedge clk_i) begin
        if (kabul) begin
            asama1_kontrol <= kontrol_i;
            asama1_deger1  <= deger1_i;
            asama1_deger2  <= deger2_i;
            asama1_hedef   <= hedef_yazmac_i;
        end
    end

    // FIFO entry write; storage contents are masked by the count at the output.
    always_ff @(posedge clk_i) begin
        if (yaz) begin
            sonuc_mem[yaz_ptr]    <= birim_sonuc;
            hedef_mem[yaz_ptr]    <= asama1_hedef;
            gecersiz_mem[yaz_ptr] <= birim_gecersiz;
        end
    end

    // Pointers and count; flush wins over push and pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            yaz_ptr <= '0;
            oku_ptr <= '0;
            sayac   <= '0;
        end else if (temizle_i) begin
            yaz_ptr <= '0;
            oku_ptr <= '0;
            sayac   <= '0;
        end else begin
            if (yaz) yaz_ptr <= yaz_ptr + PTR_W'(1);
            if (oku) oku_ptr <= oku_ptr + PTR_W'(1);
            case ({yaz, oku})
                2'b10:   sayac <= sayac + CNT_W'(1);
                2'b01:   sayac <= sayac - CNT_W'(1);
                default: sayac <= sayac;
            endcase
        end
    end
endmodule

// File: tb/tb_sifreleme_yurutme_asamasi.sv
// Bench for the crypto execute stage: directed vectors, expected results
// queued at issue time and consumed by an independent output monitor.
module tb_sifreleme_yurutme_asamasi;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        giris_gecerli = 1'b0;
    logic        giris_hazir;
    logic [2:0]  kontrol = 3'd0;
    logic [31:0] d1 = '0;
    logic [31:0] d2 = '0;
    logic [4:0]  hedef = '0;
    logic        temizle = 1'b0;
    logic        cikis_gecerli;
    logic        cikis_hazir = 1'b0;
    logic [31:0] sonuc;
    logic [4:0]  hedef_o;
    logic        gecersiz;

    sifreleme_yurutme_asamasi #(.FIFO_DERINLIK(D), .VERI_GENISLIK(32)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .giris_gecerli_i  (giris_gecerli),
        .giris_hazir_o    (giris_hazir),
        .kontrol_i        (kontrol),
        .deger1_i         (d1),
        .deger2_i         (d2),
        .hedef_yazmac_i   (hedef),
        .temizle_i        (temizle),
        .cikis_gecerli_o  (cikis_gecerli),
        .cikis_hazir_i    (cikis_hazir),
        .sonuc_o          (sonuc),
        .hedef_yazmac_o   (hedef_o),
        .gecersiz_islem_o (gecersiz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] beklenen;
        logic        inv;
    } vektor_t;

    typedef struct packed {
        logic [31:0] sonuc;
        logic [4:0]  hedef;
        logic        inv;
    } beklenen_t;

    vektor_t   tablo[15];
    beklenen_t kuyruk[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic kontrol_et(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
        vectors++;
        if (gercek !== beklenen) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", ad, gercek, beklenen, $time);
        end
    endtask

    // Hand-computed reference vectors.
    initial begin
        tablo[0]  = '{3'd0, 32'hf0f0_f0f0, 32'hfff0_f0f0, 32'd4,          1'b0};
        tablo[1]  = '{3'd1, 32'hffff_000f, 32'hffff_0f0f, 32'h0f0f_000f,  1'b0};
        tablo[2]  = '{3'd2, 32'hffff_0000, 32'h0,         32'h0000_ffff,  1'b0};
        tablo[3]  = '{3'd3, 32'd16,        32'd38,        32'd70,         1'b0};
        tablo[4]  = '{3'd4, 32'hffff_0000, 32'h0,         32'd16,         1'b0};
        tablo[5]  = '{3'd5, 32'hf000_0000, 32'h0,         32'd4,          1'b0};
        tablo[6]  = '{3'd6, 32'h1234_5678, 32'h9abc_def0, 32'd0,          1'b1};
        tablo[7]  = '{3'd5, 32'h0000_00ff, 32'h0,         32'd8,          1'b0};
        tablo[8]  = '{3'd2, 32'h1234_5678, 32'h0,         32'h7856_3412,  1'b0};
        tablo[9]  = '{3'd0, 32'hffff_ffff, 32'h0,         32'd32,         1'b0};
        tablo[10] = '{3'd4, 32'h0,         32'h0,         32'd32,         1'b0};
        tablo[11] = '{3'd3, 32'h8000_0000, 32'h1,         32'd1,          1'b0};
        tablo[12] = '{3'd1, 32'h0000_aaaa, 32'h5555_bbbb, 32'hbbbb_aaaa,  1'b0};
        tablo[13] = '{3'd7, 32'hdead_beef, 32'h1,         32'd0,          1'b1};
        tablo[14] = '{3'd4, 32'h0000_0008, 32'h0,         32'd3,          1'b0};
    end

    // Monitor: consume expected entries whenever writeback takes the head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (kuyruk.size() > D) begin
                vectors++;
                miscompares++;
                $display("FAIL kredi: outstanding %0d exceeds %0d", kuyruk.size(), D);
            end
            if (cikis_gecerli && cikis_hazir) begin
                if (kuyruk.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL beklenmeyen_sonuc: got %h/%0d/%b with nothing expected", sonuc, hedef_o, gecersiz);
                end else begin
                    beklenen_t e;
                    e = kuyruk.pop_front();
                    kontrol_et("sonuc", {26'd0, sonuc, hedef_o, gecersiz}, {26'd0, e.sonuc, e.hedef, e.inv});
                end
            end else if (!cikis_gecerli) begin
                kontrol_et("bos_cikis", {26'd0, sonuc, hedef_o, gecersiz}, 64'd0);
            end
        end
    end

    task automatic ver(input int i);
        kontrol       = tablo[i].op;
        d1            = tablo[i].a;
        d2            = tablo[i].b;
        hedef         = 5'(i * 3 + 1);
        giris_gecerli = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (giris_hazir) begin
                kuyruk.push_back({tablo[i].beklenen, hedef, tablo[i].inv});
                @(posedge clk);
                #1;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL kabul_zaman_asimi: vector %0d never accepted", i);
    endtask

    task automatic bekle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at #1 after the accept edge with writeback ready.
    task automatic gecikme(input logic [31:0] exp);
        kontrol_et("gecikme_n1", {63'd0, cikis_gecerli}, 64'd0);
        @(posedge clk);
        #1;
        kontrol_et("gecikme_n2", {63'd0, cikis_gecerli}, 64'd1);
        kontrol_et("gecikme_sonuc", {32'd0, sonuc}, {32'd0, exp});
    endtask

    initial begin
        int kabul_sayisi;
        int j;
        cikis_hazir = 1'b1;
        #12;
        kontrol_et("reset_hazir", {63'd0, giris_hazir}, 64'd0);
        kontrol_et("reset_cikis", {26'd0, cikis_gecerli, sonuc, hedef_o, gecersiz}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        kontrol_et("hazir_ilk_kenar_oncesi", {63'd0, giris_hazir}, 64'd0);
        @(posedge clk);
        #1;
        kontrol_et("hazir_ilk_kenar", {63'd0, giris_hazir}, 64'd1);

        // Two-cycle latency on HMDST.
        ver(0);
        giris_gecerli = 1'b0;
        gecikme(32'd4);
        bekle(3);

        // Back-to-back issue, one per cycle.
        for (int i = 1; i <= 5; i++) ver(i);
        giris_gecerli = 1'b0;
        @(negedge clk);
        kontrol_et("surekli_a", {63'd0, cikis_gecerli}, 64'd1);
        @(negedge clk);
        kontrol_et("surekli_b", {63'd0, cikis_gecerli}, 64'd1);
        @(negedge clk);
        kontrol_et("surekli_son", {63'd0, cikis_gecerli}, 64'd0);
        bekle(2);

        // Backpressure: fill to depth, head must hold, then drain.
        cikis_hazir   = 1'b0;
        kabul_sayisi  = 0;
        giris_gecerli = 1'b1;
        for (int c = 0; c < 10; c++) begin
            j       = 7 + kabul_sayisi;
            kontrol = tablo[j].op;
            d1      = tablo[j].a;
            d2      = tablo[j].b;
            hedef   = 5'(j * 3 + 1);
            @(negedge clk);
            if (giris_hazir) begin
                kuyruk.push_back({tablo[j].beklenen, hedef, tablo[j].inv});
                kabul_sayisi++;
            end
            @(posedge clk);
            #1;
        end
        giris_gecerli = 1'b0;
        kontrol_et("dolu_kabul_sayisi", 64'(kabul_sayisi), 64'(D));
        kontrol_et("dolu_hazir", {63'd0, giris_hazir}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            kontrol_et("bas_sabit", {26'd0, sonuc, hedef_o, cikis_gecerli}, {26'd0, 32'd8, 5'd22, 1'b1});
        end
        cikis_hazir = 1'b1;
        for (int k = 0; k < 20 && kuyruk.size() != 0; k++) @(posedge clk);
        #1;
        kontrol_et("bosalma", 64'(kuyruk.size()), 64'd0);
        kontrol_et("hazir_geri", {63'd0, giris_hazir}, 64'd1);

        // Unsupported codes followed by valid ops.
        ver(6);
        ver(12);
        ver(13);
        ver(14);
        giris_gecerli = 1'b0;
        bekle(6);

        // Flush with 3 buffered + 1 in stage 1, concurrent valid presented.
        cikis_hazir = 1'b0;
        for (int i = 1; i <= 4; i++) ver(i);
        kontrol = tablo[5].op;
        d1      = tablo[5].a;
        d2      = tablo[5].b;
        hedef   = 5'd30;
        temizle = 1'b1;
        @(posedge clk);
        #1;
        temizle       = 1'b0;
        giris_gecerli = 1'b0;
        kuyruk.delete();
        @(negedge clk);
        kontrol_et("temizle_bos", {63'd0, cikis_gecerli}, 64'd0);
        kontrol_et("temizle_hazir", {63'd0, giris_hazir}, 64'd1);
        // Flush with a genuine accept in the same cycle.
        giris_gecerli = 1'b1;
        temizle       = 1'b1;
        @(posedge clk);
        #1;
        temizle       = 1'b0;
        giris_gecerli = 1'b0;
        @(negedge clk);
        kontrol_et("temizle_kabul_a", {63'd0, cikis_gecerli}, 64'd0);
        @(negedge clk);
        kontrol_et("temizle_kabul_b", {63'd0, cikis_gecerli}, 64'd0);
        cikis_hazir = 1'b1;
        bekle(4);
        ver(8);
        giris_gecerli = 1'b0;
        bekle(4);

        // Asynchronous reset mid-stream.
        cikis_hazir = 1'b0;
        ver(9);
        ver(10);
        ver(11);
        giris_gecerli = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        kuyruk.delete();
        #1;
        kontrol_et("async_reset_cikis", {25'd0, giris_hazir, cikis_gecerli, sonuc, hedef_o, gecersiz}, 64'd0);
        #3;
        rst_n = 1'b1;
        #1;
        kontrol_et("reset_sonrasi_hazir", {63'd0, giris_hazir}, 64'd0);
        @(posedge clk);
        #1;
        kontrol_et("reset_sonrasi_hazir_kenar", {63'd0, giris_hazir}, 64'd1);
        cikis_hazir = 1'b1;
        ver(3);
        giris_gecerli = 1'b0;
        gecikme(32'd70);
        bekle(4);
        kontrol_et("son_kuyruk", 64'(kuyruk.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL zaman_asimi: bench did not complete");
        $fatal(1);
    end
endmodule
